// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Sequencing controller for the fetch-stage PC register. It produces the
//   next-PC value and the PC write enable, and drives the IF/ID enable and
//   the D/E bubble. There are three sources of control:
//     - D-stage branch/jump redirects,
//     - data-hazard stalls from the hazard unit,
//     - an internal mult/div busy tracker (IDLE/BUSY counter FSM).
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   pc         in   32  current PC (PC register output)
//   br_taken   in   1   D-stage branch/jump resolved taken
//   br_target  in   32  D-stage redirect target (low two bits forced to 0)
//   hz_stall   in   1   data-hazard stall request
//   md_start   in   1   E-stage mult/div issue pulse
//   md_is_div  in   1   qualifies md_start: 1 = div/divu, 0 = mult/multu
//   md_use     in   1   D-stage instruction touches the mult/div unit or HI/LO
//   npc        out  32  next PC, to PC register input
//   pc_en      out  1   PC register write enable
//   fd_en      out  1   IF/ID pipeline register enable
//   de_flush   out  1   clear D/E register (insert bubble)
//   md_busy    out  1   mult/div unit busy (registered)
//
// Optional feature, macro FETCH_PERF_EN:
//   stall_cnt  out  32  count of stalled cycles outside reset (wraps)
//   md_stall   out  1   stall caused by the mult/div unit
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int          MULT_CYCLES = 5,
    parameter int          DIV_CYCLES  = 10,
    parameter int          CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        hz_stall,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        md_use,
`ifdef FETCH_PERF_EN
    output logic [31:0] stall_cnt,
    output logic        md_stall,
`endif
    output logic [31:0] npc,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_flush,
    output logic        md_busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_busy_q, md_busy_d;
    logic             md_stall_s;
    logic             stall_s;

    // Busy tracker next-state: load on issue, count down, return to IDLE at 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (md_start) begin
                    cnt_d   = md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d = BUSY;
                end else begin
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            BUSY: begin
                // A second issue while busy cannot happen upstream, so it is ignored.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        md_busy_d = (state_d == BUSY);
    end

    // Busy tracker state, counter and registered busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            md_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_busy_q <= md_busy_d;
        end
    end

    assign md_busy = md_busy_q;

    // The issue cycle already counts as busy so a dependent mfhi/mflo right
    // behind the mult/div stalls without a gap.
    assign md_stall_s = md_use & (md_busy_q | md_start);
    assign stall_s    = hz_stall | md_stall_s;

    // PC sequencing: reset overrides, a stall holds the PC and drops any
    // pending redirect (the branch is re-evaluated once the stall releases).
    always_comb begin
        npc      = pc;
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        de_flush = 1'b1;
        if (reset) begin
            npc      = RESET_PC;
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_flush = 1'b1;
        end else if (stall_s) begin
            npc      = pc;
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_flush = 1'b1;
        end else begin
            npc      = br_taken ? {br_target[31:2], 2'b00} : (pc + 32'd4);
            pc_en    = 1'b1;
            fd_en    = 1'b1;
            de_flush = 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Stall counter increment; wraps naturally at 32 bits.
    always_comb begin
        if (stall_s) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register; held at zero while reset is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign md_stall  = md_stall_s;
`endif

endmodule
